alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares the single datapath ALU between NUM_REQ requesters (e.g. main datapath, branch/address unit).
//  Each cycle it grants at most one requester by round-robin and drives the ALU ports.
//  It captures ALU_Result/ALU_Zero into a one-entry response buffer and returns them with the requester ID.
//  It sits between the requesters and the ALU. The ALU itself stays purely combinational.
// PARAMETERS
//  WIDTH    32  ALU operand/result width
//  NUM_REQ  2   number of requesters (2..8)
//  ID_W     3   width of Rsp_Id (>= clog2(NUM_REQ))
// PORTS
//  clk          in   1              rising-edge clock
//  rst_n        in   1              synchronous reset, active-low
//  Req_Valid    in   NUM_REQ        per-requester request valid
//  Req_Ready    out  NUM_REQ        one-hot grant/accept, combinational
//  Req_Ctrl     in   NUM_REQ*3      per-requester ALU_Control code, requester i at [3i+:3]
//  Req_SrcA     in   NUM_REQ*WIDTH  per-requester operand A, at [WIDTH*i+:WIDTH]
//  Req_SrcB     in   NUM_REQ*WIDTH  per-requester operand B
//  ALU_Control  out  3              to ALU: 000 and, 001 or, 010 add, 110 sub, 111 slt
//  ALU_SrcA     out  WIDTH          to ALU operand A
//  ALU_SrcB     out  WIDTH          to ALU operand B
//  ALU_Result   in   WIDTH          from ALU, combinational on ALU_* in the same cycle
//  ALU_Zero     in   1              from ALU
//  Rsp_Valid    out  1              response buffer holds a result
//  Rsp_Ready    in   1              consumer accepts the response this cycle
//  Rsp_Id       out  ID_W           index of the requester that issued the response
//  Rsp_Result   out  WIDTH          registered ALU_Result
//  Rsp_Zero     out  1              registered ALU_Zero
//  Rsp_Err      out  1              issued code was 011, 100 or 101 (illegal)
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge) has these effects:
//    - Rsp_Valid=0, Rsp_Id=0, Rsp_Result=0, Rsp_Zero=0, Rsp_Err=0.
//    - State goes to EMPTY and the RR pointer goes to 0 (requester 0 highest priority).
//    - A pending response is dropped, including when reset is asserted mid-operation.
//  - Req_Ready must be 0 while rst_n==0.
//  - FSM has two states:
//    - EMPTY: no response buffered.
//    - FULL: Rsp_Valid=1.
//  - can_issue = (state==EMPTY) | Rsp_Ready. No grant is given when can_issue==0.
//  - Grant selection:
//    - The winner is the first Req_Valid bit at or after ptr, scanning upward with wrap to 0.
//    - Req_Ready[winner]=1 only if can_issue. All other bits are 0.
//  - A transfer occurs when Req_Valid[i] & Req_Ready[i].
//  - On a transfer:
//    - ALU_* are driven from requester i in the same cycle.
//    - At the posedge the buffer loads ALU_Result, ALU_Zero, id=i and the err flag.
//    - State becomes FULL.
//    - ptr becomes (i+1) mod NUM_REQ.
//  - Latency is 1 cycle from request to Rsp_Valid. Throughput is 1 per cycle while Rsp_Ready stays 1.
//  - No transfer this cycle:
//    - ALU_Control=3'b000 and ALU_SrcA=ALU_SrcB=0.
//    - ptr is unchanged.
//    - If FULL & Rsp_Ready, the state becomes EMPTY.
//  - Simultaneous accept and new issue while FULL: the buffer is overwritten with the new result and state stays FULL.
//  - Backpressure (FULL & !Rsp_Ready): all Rsp_* outputs hold stable and no grant is given.
//  - Requester-side rules:
//    - A requester keeps Req_Valid and its payload stable until granted.
//    - The arbiter does not latch ungranted requests.
//  - Illegal codes 011, 100 and 101 are forwarded unchanged to the ALU and set Rsp_Err with the response.
//    The result is the ALU's default output.
//  - Starvation bound: a requester holding Req_Valid is granted within NUM_REQ issue opportunities.
// STRUCTURE
//  - Package alu_pkg holds the ALU_Control code localparams: ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010,
//    ALU_SUB=3'b110, ALU_SLT=3'b111. It also holds the is_legal_ctrl() function, shared with ALU_Control decode.
//  - Sub-module rr_arbiter (NUM_REQ) has these ports:
//    - inputs: req, ptr, en
//    - outputs: one-hot grant, encoded grant_id
//  - The top level contains the FSM, the mux to the ALU and the response register.
// TESTING (bench includes a behavioural ALU model; WIDTH=32, NUM_REQ=2)
//  1. Reset, then single issue:
//     - Stimulus: req0 add 5+7 with Rsp_Ready=1.
//     - Response: Req_Ready=01 in cycle 0; next cycle Rsp_Valid=1, Id=0, Result=12, Zero=0, Err=0.
//  2. Both requesting continuously with Rsp_Ready=1:
//     - req0 is sub 9-9 and req1 is slt 3<4.
//     - Grants alternate 0,1,0,1; responses are (0,0,Zero=1) and (1,1,Zero=0).
//  3. Backpressure:
//     - Stimulus: Rsp_Ready=0 for 3 cycles after an issue.
//     - Response: Rsp_* stable, Req_Ready=00. When Rsp_Ready=1, the next grant is given in that same cycle.
//  4. Illegal code 3'b101 from req1:
//     - Response: Rsp_Err=1, Id=1. The next legal op returns Err=0.
//  5. Reset mid-operation:
//     - Stimulus: rst_n=0 while FULL with Rsp_Ready=0.
//     - Response: next cycle Rsp_Valid=0, ptr=0. With both requesting after release, req0 is granted first.
//  6. Idle cycle with no Req_Valid:
//     - Response: ALU_Control=000, ALU_SrcA/SrcB=0, and the FULL response drains on Rsp_Ready.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU control codes, arbiter FSM state type and the shared legality decode.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Codes 011, 100 and 101 have no ALU operation behind them.
  function automatic logic is_legal_ctrl(input logic [2:0] ctrl);
    case (ctrl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: is_legal_ctrl = 1'b1;
      default:                                    is_legal_ctrl = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request, ALU-side and response signals of the shared-ALU arbiter.
// slave is the arbiter's view; master is the surrounding environment's view.
interface alu_share_arbiter_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3
);
  logic [NUM_REQ-1:0]       Req_Valid;
  logic [NUM_REQ-1:0]       Req_Ready;
  logic [NUM_REQ*3-1:0]     Req_Ctrl;
  logic [NUM_REQ*WIDTH-1:0] Req_SrcA;
  logic [NUM_REQ*WIDTH-1:0] Req_SrcB;

  logic [2:0]               ALU_Control;
  logic [WIDTH-1:0]         ALU_SrcA;
  logic [WIDTH-1:0]         ALU_SrcB;
  logic [WIDTH-1:0]         ALU_Result;
  logic                     ALU_Zero;

  logic                     Rsp_Valid;
  logic                     Rsp_Ready;
  logic [ID_W-1:0]          Rsp_Id;
  logic [WIDTH-1:0]         Rsp_Result;
  logic                     Rsp_Zero;
  logic                     Rsp_Err;

  modport slave (
    input  Req_Valid, Req_Ctrl, Req_SrcA, Req_SrcB, ALU_Result, ALU_Zero, Rsp_Ready,
    output Req_Ready, ALU_Control, ALU_SrcA, ALU_SrcB,
           Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Zero, Rsp_Err
  );

  modport master (
    output Req_Valid, Req_Ctrl, Req_SrcA, Req_SrcB, ALU_Result, ALU_Zero, Rsp_Ready,
    input  Req_Ready, ALU_Control, ALU_SrcA, ALU_SrcB,
           Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Zero, Rsp_Err
  );
endinterface

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted req at or above ptr, wrapping to 0.
// grant_id reports the winner even when en is low; grant is gated by en.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic found;
  int   win;
  int   idx;

  // Scan upward from ptr with wrap and keep the first requester seen.
  always_comb begin
    found    = 1'b0;
    win      = 0;
    idx      = 0;
    grant    = '0;
    grant_id = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    grant_id = ID_W'(win);
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = en & found & (win == i);
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters and returns
// each result through a one-entry response buffer tagged with the requester id.
//
// state    | meaning
// ST_EMPTY | no response buffered, a grant is always possible
// ST_FULL  | response buffered (Rsp_Valid=1), grant only if it is consumed now
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
  logic               rsp_zero_q, rsp_zero_d;
  logic               rsp_err_q, rsp_err_d;

  logic               can_issue;
  logic               arb_en;
  logic               xfer;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic [2:0]         alu_ctrl;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;

  // A slot opens when the buffer is empty or is being drained this cycle;
  // rst_n gates the grant so nothing is accepted while in reset.
  assign can_issue = (state_q == ST_EMPTY) | bus.Rsp_Ready;
  assign arb_en    = can_issue & rst_n;
  assign xfer      = |grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req      (bus.Req_Valid),
    .ptr      (ptr_q),
    .en       (arb_en),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Route the granted requester to the ALU; drive zeros when idle.
  always_comb begin
    alu_ctrl = ALU_AND;
    alu_a    = '0;
    alu_b    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        alu_ctrl = bus.Req_Ctrl[3*i +: 3];
        alu_a    = bus.Req_SrcA[WIDTH*i +: WIDTH];
        alu_b    = bus.Req_SrcB[WIDTH*i +: WIDTH];
      end
    end
  end

  assign bus.Req_Ready   = grant;
  assign bus.ALU_Control = alu_ctrl;
  assign bus.ALU_SrcA    = alu_a;
  assign bus.ALU_SrcB    = alu_b;

  // Next state: a transfer (re)fills the buffer, otherwise a consumed response empties it.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    if (xfer) begin
      state_d      = ST_FULL;
      ptr_d        = PTR_W'((int'(grant_id) + 1) % NUM_REQ);
      rsp_id_d     = grant_id;
      rsp_result_d = bus.ALU_Result;
      rsp_zero_d   = bus.ALU_Zero;
      rsp_err_d    = ~is_legal_ctrl(alu_ctrl);
    end else if (state_q == ST_FULL && bus.Rsp_Ready) begin
      state_d = ST_EMPTY;
    end
  end

  // State, pointer and response buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      ptr_q        <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.Rsp_Valid  = (state_q == ST_FULL);
  assign bus.Rsp_Id     = rsp_id_q;
  assign bus.Rsp_Result = rsp_result_q;
  assign bus.Rsp_Zero   = rsp_zero_q;
  assign bus.Rsp_Err    = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter with a behavioural ALU and a response scoreboard.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  alu_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             err;
  } rsp_t;

  rsp_t sb_q[$];
  rsp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [WIDTH-1:0] alu_model(input logic [2:0] c,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    case (c)
      3'b000:  alu_model = a & b;
      3'b001:  alu_model = a | b;
      3'b010:  alu_model = a + b;
      3'b110:  alu_model = a - b;
      3'b111:  alu_model = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
      default: alu_model = '0;
    endcase
  endfunction

  // Behavioural ALU hanging off the arbiter's ALU ports.
  always_comb begin
    bus.ALU_Result = alu_model(bus.ALU_Control, bus.ALU_SrcA, bus.ALU_SrcB);
    bus.ALU_Zero   = (alu_model(bus.ALU_Control, bus.ALU_SrcA, bus.ALU_SrcB) == '0);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] c,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.Req_Valid[i]              = v;
    bus.Req_Ctrl[3*i +: 3]        = c;
    bus.Req_SrcA[WIDTH*i +: WIDTH] = a;
    bus.Req_SrcB[WIDTH*i +: WIDTH] = b;
  endtask

  // Scoreboard: compare on response handshake, push on request handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      chk("ready_onehot", 64'($onehot0(bus.Req_Ready)), 64'd1);
      chk("ready_only_valid", 64'(bus.Req_Ready & ~bus.Req_Valid), 64'd0);
      if (bus.Rsp_Valid && bus.Rsp_Ready) begin
        chk("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          chk("rsp_id",     64'(bus.Rsp_Id),     64'(mon_e.id));
          chk("rsp_result", 64'(bus.Rsp_Result), 64'(mon_e.res));
          chk("rsp_zero",   64'(bus.Rsp_Zero),   64'(mon_e.zero));
          chk("rsp_err",    64'(bus.Rsp_Err),    64'(mon_e.err));
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.Req_Valid[i] && bus.Req_Ready[i]) begin
          mon_e.id   = ID_W'(i);
          mon_e.res  = alu_model(bus.Req_Ctrl[3*i +: 3], bus.Req_SrcA[WIDTH*i +: WIDTH],
                                 bus.Req_SrcB[WIDTH*i +: WIDTH]);
          mon_e.zero = (mon_e.res == '0);
          mon_e.err  = !(bus.Req_Ctrl[3*i +: 3] inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111});
          sb_q.push_back(mon_e);
        end
      end
    end
  end

  initial begin
    bus.Req_Valid = '0;
    bus.Req_Ctrl  = '0;
    bus.Req_SrcA  = '0;
    bus.Req_SrcB  = '0;
    bus.Rsp_Ready = 1'b0;

    // 1: reset, then a single add
    set_req(0, 1'b1, ALU_ADD, 32'd5, 32'd7);
    bus.Rsp_Ready = 1'b1;
    step();
    @(negedge clk);
    chk("t1_ready_in_reset", 64'(bus.Req_Ready), 64'd0);
    chk("t1_rsp_valid_reset", 64'(bus.Rsp_Valid), 64'd0);
    chk("t1_rsp_result_reset", 64'(bus.Rsp_Result), 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_grant", 64'(bus.Req_Ready), 64'b01);
    step();
    set_req(0, 1'b0, ALU_AND, '0, '0);
    @(negedge clk);
    chk("t1_rsp_valid", 64'(bus.Rsp_Valid), 64'd1);
    chk("t1_rsp_id", 64'(bus.Rsp_Id), 64'd0);
    chk("t1_rsp_result", 64'(bus.Rsp_Result), 64'd12);
    chk("t1_rsp_zero", 64'(bus.Rsp_Zero), 64'd0);
    chk("t1_rsp_err", 64'(bus.Rsp_Err), 64'd0);
    step();

    // 2: both requesting continuously, grants alternate from requester 0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_req(0, 1'b1, ALU_SUB, 32'd9, 32'd9);
    set_req(1, 1'b1, ALU_SLT, 32'd3, 32'd4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_grant", 64'(bus.Req_Ready), (k % 2 == 0) ? 64'b01 : 64'b10);
      step();
    end
    set_req(0, 1'b0, ALU_AND, '0, '0);
    set_req(1, 1'b0, ALU_AND, '0, '0);
    @(negedge clk);
    chk("t2_last_id", 64'(bus.Rsp_Id), 64'd1);
    step();

    // 3: backpressure holds the response and blocks grants
    set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd2);
    @(negedge clk);
    chk("t3_grant0", 64'(bus.Req_Ready), 64'b01);
    step();
    bus.Rsp_Ready = 1'b0;
    set_req(0, 1'b0, ALU_AND, '0, '0);
    set_req(1, 1'b1, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_bp_ready", 64'(bus.Req_Ready), 64'd0);
      chk("t3_bp_valid", 64'(bus.Rsp_Valid), 64'd1);
      chk("t3_bp_result", 64'(bus.Rsp_Result), 64'd3);
      chk("t3_bp_id", 64'(bus.Rsp_Id), 64'd0);
      step();
    end
    bus.Rsp_Ready = 1'b1;
    @(negedge clk);
    chk("t3_release_grant", 64'(bus.Req_Ready), 64'b10);
    step();
    set_req(1, 1'b0, ALU_AND, '0, '0);
    @(negedge clk);
    chk("t3_or_result", 64'(bus.Rsp_Result), 64'h0000_00FF);
    step();

    // 4: illegal code from requester 1, then a legal op
    set_req(1, 1'b1, 3'b101, 32'd5, 32'd6);
    @(negedge clk);
    chk("t4_grant", 64'(bus.Req_Ready), 64'b10);
    chk("t4_ctrl_forwarded", 64'(bus.ALU_Control), 64'b101);
    step();
    set_req(1, 1'b1, ALU_AND, 32'hC, 32'hA);
    @(negedge clk);
    chk("t4_err", 64'(bus.Rsp_Err), 64'd1);
    chk("t4_err_id", 64'(bus.Rsp_Id), 64'd1);
    step();
    set_req(1, 1'b0, ALU_AND, '0, '0);
    @(negedge clk);
    chk("t4_legal_err", 64'(bus.Rsp_Err), 64'd0);
    chk("t4_legal_result", 64'(bus.Rsp_Result), 64'h8);
    step();

    // 5: reset while FULL and stalled drops the response and the pointer
    set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd1);
    @(negedge clk);
    chk("t5_grant0", 64'(bus.Req_Ready), 64'b01);
    step();
    set_req(0, 1'b0, ALU_AND, '0, '0);
    bus.Rsp_Ready = 1'b0;
    @(negedge clk);
    chk("t5_full", 64'(bus.Rsp_Valid), 64'd1);
    step();
    rst_n = 1'b0;
    step();
    set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd1);
    set_req(1, 1'b1, ALU_ADD, 32'd2, 32'd2);
    @(negedge clk);
    chk("t5_rsp_valid", 64'(bus.Rsp_Valid), 64'd0);
    chk("t5_rsp_result", 64'(bus.Rsp_Result), 64'd0);
    chk("t5_rsp_id", 64'(bus.Rsp_Id), 64'd0);
    chk("t5_ready_in_reset", 64'(bus.Req_Ready), 64'd0);
    step();
    rst_n = 1'b1;
    bus.Rsp_Ready = 1'b1;
    @(negedge clk);
    chk("t5_first_grant", 64'(bus.Req_Ready), 64'b01);
    step();
    set_req(0, 1'b0, ALU_AND, '0, '0);
    set_req(1, 1'b0, ALU_AND, '0, '0);
    @(negedge clk);
    chk("t5_post_id", 64'(bus.Rsp_Id), 64'd0);
    step();

    // 6: idle cycle drives zeros to the ALU and the held response drains
    set_req(1, 1'b1, ALU_OR, 32'h30, 32'h03);
    @(negedge clk);
    chk("t6_grant", 64'(bus.Req_Ready), 64'b10);
    step();
    set_req(1, 1'b0, ALU_AND, '0, '0);
    bus.Rsp_Ready = 1'b0;
    @(negedge clk);
    chk("t6_idle_ctrl", 64'(bus.ALU_Control), 64'd0);
    chk("t6_idle_srca", 64'(bus.ALU_SrcA), 64'd0);
    chk("t6_idle_srcb", 64'(bus.ALU_SrcB), 64'd0);
    chk("t6_held", 64'(bus.Rsp_Valid), 64'd1);
    step();
    bus.Rsp_Ready = 1'b1;
    @(negedge clk);
    chk("t6_drain_result", 64'(bus.Rsp_Result), 64'h33);
    step();
    @(negedge clk);
    chk("t6_empty", 64'(bus.Rsp_Valid), 64'd0);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
